// File: rtl/fetch_stage_if.sv
// fetch_stage_if: instruction-memory, redirect and IF/ID handshake signals of the fetch stage.
interface fetch_stage_if;
    logic [31:0] instr_addr;
    logic        instr_req;
    logic [31:0] instr;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        IF_ID_valid;
    logic        IF_ID_ready;
    logic [31:0] IF_ID_instr;
    logic [31:0] IF_ID_pc;
    modport master (
        output instr_addr, instr_req, IF_ID_valid, IF_ID_instr, IF_ID_pc,
        input  instr, redirect_valid, redirect_pc, IF_ID_ready
    );
    modport slave (
        input  instr_addr, instr_req, IF_ID_valid, IF_ID_instr, IF_ID_pc,
        output instr, redirect_valid, redirect_pc, IF_ID_ready
    );
endinterface

// File: rtl/fetch_stage.sv
// fetch_stage: sequential instruction fetch with redirect, one-cycle memory and 2-entry IF/ID FIFO.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input logic           clk,
    input logic           rst_n,
    fetch_stage_if.master bus
);
    logic [31:0] pc_q, pc_d;
    logic [31:0] inflight_pc_q, inflight_pc_d;
    logic        inflight_q, inflight_d;
    logic [1:0]  count_q, count_d;
    logic        rd_ptr_q, rd_ptr_d;
    logic [31:0] instr_q [2];
    logic [31:0] instr_d [2];
    logic [31:0] epc_q [2];
    logic [31:0] epc_d [2];
    logic        valid, pop, push, req, wr_ptr;
    logic [2:0]  occ;

    always_comb begin
        valid         = (count_q != 2'd0) & ~bus.redirect_valid;
        pop           = valid & bus.IF_ID_ready;
        push          = inflight_q & ~bus.redirect_valid;
        // Slots committed after this edge: buffered plus the response still on its way.
        occ           = {1'b0, count_q} + {2'b0, inflight_q} - {2'b0, pop};
        req           = rst_n & ~bus.redirect_valid & (occ < 3'd2);
        wr_ptr        = rd_ptr_q ^ count_q[0];
        pc_d          = pc_q;
        inflight_d    = inflight_q;
        inflight_pc_d = inflight_pc_q;
        count_d       = count_q;
        rd_ptr_d      = rd_ptr_q;
        instr_d       = instr_q;
        epc_d         = epc_q;
        if (bus.redirect_valid) begin
            pc_d       = bus.redirect_pc & ~32'h3;
            count_d    = 2'd0;
            inflight_d = 1'b0;
        end else begin
            pc_d          = req ? pc_q + 32'd4 : pc_q;
            inflight_d    = req;
            inflight_pc_d = req ? pc_q : inflight_pc_q;
            if (push) begin
                instr_d[wr_ptr] = bus.instr;
                epc_d[wr_ptr]   = inflight_pc_q;
            end
            rd_ptr_d = rd_ptr_q ^ pop;
            count_d  = count_q + {1'b0, push} - {1'b0, pop};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q          <= RESET_PC;
            inflight_q    <= 1'b0;
            inflight_pc_q <= 32'h0;
            count_q       <= 2'd0;
            rd_ptr_q      <= 1'b0;
            instr_q       <= '{default: 32'h0};
            epc_q         <= '{default: 32'h0};
        end else begin
            pc_q          <= pc_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
            count_q       <= count_d;
            rd_ptr_q      <= rd_ptr_d;
            instr_q       <= instr_d;
            epc_q         <= epc_d;
        end
    end

    assign bus.instr_addr  = pc_q;
    assign bus.instr_req   = req;
    assign bus.IF_ID_valid = valid;
    assign bus.IF_ID_instr = instr_q[rd_ptr_q];
    assign bus.IF_ID_pc    = epc_q[rd_ptr_q];
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed and random stimulus against a sequential-PC stream scoreboard.
module tb_fetch_stage;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    logic clk = 1'b0;
    logic rst_n = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;
    logic [31:0] exp_pc = RESET_PC;

    fetch_stage_if bus();
    fetch_stage #(.RESET_PC(RESET_PC)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;
    // Memory answers with the requested address as data, one cycle later.
    always @(posedge clk) bus.instr <= bus.instr_addr;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %h want %h", tag, got, want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Apply this cycle's inputs, then score any handoff against the expected PC stream.
    task automatic drive(input logic rdy, input logic rv, input logic [31:0] rpc);
        bus.IF_ID_ready    = rdy;
        bus.redirect_valid = rv;
        bus.redirect_pc    = rpc;
        #1;
        if (rv) begin
            check("redirect_valid_low", {31'b0, bus.IF_ID_valid}, 32'd0);
            check("redirect_req_low", {31'b0, bus.instr_req}, 32'd0);
            exp_pc = rpc & ~32'h3;
        end else if (bus.IF_ID_valid && rdy) begin
            check("accept_pc", bus.IF_ID_pc, exp_pc);
            check("accept_instr", bus.IF_ID_instr, exp_pc);
            exp_pc += 32'd4;
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_valid"}, {31'b0, bus.IF_ID_valid}, 32'd0);
        check({tag, "_req"}, {31'b0, bus.instr_req}, 32'd0);
        check({tag, "_addr"}, bus.instr_addr, RESET_PC);
        check({tag, "_pc"}, bus.IF_ID_pc, 32'd0);
        check({tag, "_instr"}, bus.IF_ID_instr, 32'd0);
    endtask

    task automatic do_reset(input logic rdy);
        rst_n              = 1'b0;
        bus.IF_ID_ready    = rdy;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 32'h0;
        #1;
        check_reset_outputs("reset");
        tick();
        tick();
        rst_n  = 1'b1;
        exp_pc = RESET_PC;
    endtask

    initial begin
        logic [31:0] wrap_addr [3];
        wrap_addr = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000};
        #2;
        // Streaming from reset with decode always ready.
        do_reset(1'b1);
        for (int k = 0; k < 8; k++) begin
            drive(1'b1, 1'b0, 32'h0);
            check("stream_addr", bus.instr_addr, RESET_PC + 32'(4 * k));
            check("stream_req", {31'b0, bus.instr_req}, 32'd1);
            if (k >= 2) begin
                check("stream_valid", {31'b0, bus.IF_ID_valid}, 32'd1);
                check("stream_pc", bus.IF_ID_pc, RESET_PC + 32'(4 * (k - 2)));
            end
            tick();
        end
        // Backpressure: FIFO fills to two, fetching stops, head holds.
        do_reset(1'b0);
        for (int k = 0; k < 2; k++) begin
            drive(1'b0, 1'b0, 32'h0);
            tick();
        end
        for (int j = 0; j < 5; j++) begin
            drive(1'b0, 1'b0, 32'h0);
            check("stall_valid", {31'b0, bus.IF_ID_valid}, 32'd1);
            check("stall_head", bus.IF_ID_pc, RESET_PC);
            check("stall_req", {31'b0, bus.instr_req}, 32'd0);
            tick();
        end
        for (int j = 0; j < 3; j++) begin
            drive(1'b1, 1'b0, 32'h0);
            check("drain_valid", {31'b0, bus.IF_ID_valid}, 32'd1);
            check("drain_pc", bus.IF_ID_pc, RESET_PC + 32'(4 * j));
            tick();
        end
        // Redirect with a full FIFO.
        for (int j = 0; j < 4; j++) begin
            drive(1'b0, 1'b0, 32'h0);
            tick();
        end
        drive(1'b0, 1'b1, 32'h0000_0103);
        tick();
        drive(1'b1, 1'b0, 32'h0);
        check("redir_addr", bus.instr_addr, 32'h0000_0100);
        check("redir_req", {31'b0, bus.instr_req}, 32'd1);
        tick();
        drive(1'b1, 1'b0, 32'h0);
        check("redir_gap", {31'b0, bus.IF_ID_valid}, 32'd0);
        tick();
        drive(1'b1, 1'b0, 32'h0);
        check("redir_valid", {31'b0, bus.IF_ID_valid}, 32'd1);
        check("redir_pc", bus.IF_ID_pc, 32'h0000_0100);
        tick();
        // Address wrap at the top of memory.
        drive(1'b1, 1'b1, 32'hFFFF_FFF8);
        tick();
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 1'b0, 32'h0);
            check("wrap_addr", bus.instr_addr, wrap_addr[k]);
            check("wrap_req", {31'b0, bus.instr_req}, 32'd1);
            tick();
        end
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, 1'b0, 32'h0);
            tick();
        end
        // One-cycle reset pulse with two entries buffered.
        for (int k = 0; k < 4; k++) begin
            drive(1'b0, 1'b0, 32'h0);
            tick();
        end
        check("pre_pulse_valid", {31'b0, bus.IF_ID_valid}, 32'd1);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("pulse");
        tick();
        rst_n  = 1'b1;
        exp_pc = RESET_PC;
        drive(1'b1, 1'b0, 32'h0);
        check("restart_addr", bus.instr_addr, RESET_PC);
        check("restart_req", {31'b0, bus.instr_req}, 32'd1);
        tick();
        for (int k = 0; k < 5; k++) begin
            drive(1'b1, 1'b0, 32'h0);
            tick();
        end
        // Random backpressure and redirects, scored against the PC stream.
        repeat (3000) begin
            logic rv, rdy;
            rv  = ($urandom_range(15) == 0);
            rdy = ($urandom_range(3) != 0);
            drive(rdy, rv, $urandom);
            tick();
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
